// File: rtl/sreg_pkg.sv
// Shared types for the scalar-register writeback path.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package sreg_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    // One pending register-file write.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

    // Source selected for the write-port register in a given cycle.
    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_LSU
    } wb_src_e;

    // A result only counts as a write when it is valid and not aimed at x0.
    function automatic logic is_write(input logic vld, input logic [REG_ADDR_W-1:0] rd);
        return vld && (rd != '0);
    endfunction

endpackage

// File: rtl/sreg_wb_arbiter_if.sv
// Bundles the writeback arbiter's result, hazard-query and register-file signals.
// Latency: n/a (wiring only).
// Backpressure: lsu_ready_o / stall_o travel back to the producers.
// Modports: master = producers/decode/register file side, slave = arbiter side.
interface sreg_wb_arbiter_if
    import sreg_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W
);
    // ALU results (no backpressure apart from the stall request)
    logic                  alu_valid_i;
    logic [REG_ADDR_W-1:0] alu_rd_i;
    logic [DATA_WIDTH-1:0] alu_data_i;
    // LSU load results (valid/ready)
    logic                  lsu_valid_i;
    logic                  lsu_ready_o;
    logic [REG_ADDR_W-1:0] lsu_rd_i;
    logic [DATA_WIDTH-1:0] lsu_data_i;
    logic                  stall_o;
    // Decode hazard query
    logic [REG_ADDR_W-1:0] rs1_addr_i;
    logic [REG_ADDR_W-1:0] rs2_addr_i;
    logic                  pend_rs1_o;
    logic                  pend_rs2_o;
    // Register file write port
    logic [REG_ADDR_W-1:0] rd_addr_o;
    logic [DATA_WIDTH-1:0] rd_data_o;
    logic                  reg_write_en_o;
    logic                  err_o;

    modport master (
        output alu_valid_i, alu_rd_i, alu_data_i,
        output lsu_valid_i, lsu_rd_i, lsu_data_i,
        output rs1_addr_i, rs2_addr_i,
        input  lsu_ready_o, stall_o, pend_rs1_o, pend_rs2_o,
        input  rd_addr_o, rd_data_o, reg_write_en_o, err_o
    );

    modport slave (
        input  alu_valid_i, alu_rd_i, alu_data_i,
        input  lsu_valid_i, lsu_rd_i, lsu_data_i,
        input  rs1_addr_i, rs2_addr_i,
        output lsu_ready_o, stall_o, pend_rs1_o, pend_rs2_o,
        output rd_addr_o, rd_data_o, reg_write_en_o, err_o
    );

endinterface

// File: rtl/sreg_wb_fifo.sv
// Small synchronous FIFO of load writebacks; every slot is visible for hazard checks.
// Latency: push in cycle N is visible at the head in cycle N+1.
// Backpressure: push ignored while full, pop ignored while empty; push+pop together allowed.
// Ports: clk/rst, push/push_dat, pop/pop_dat (head), full/empty, entries/entry_vld.
module sreg_wb_fifo
    import sreg_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  wb_req_t               push_dat,
    input  logic                  pop,
    output wb_req_t               pop_dat,
    output logic                  full,
    output logic                  empty,
    output wb_req_t [DEPTH-1:0]   entries,
    output logic    [DEPTH-1:0]   entry_vld
);

    localparam int AW = $clog2(DEPTH);

    // Extra MSB on each pointer separates full (MSBs differ) from empty (equal).
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic [AW-1:0]        wr_idx;
    logic [AW-1:0]        rd_idx;
    wb_req_t [DEPTH-1:0]  mem;
    logic    [DEPTH-1:0]  vld_q;
    logic    [DEPTH-1:0]  vld_nxt;
    logic                 push_ok;
    logic                 pop_ok;

    assign wr_idx  = wr_ptr[AW-1:0];
    assign rd_idx  = rd_ptr[AW-1:0];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign pop_dat   = mem[rd_idx];
    assign entries   = mem;
    assign entry_vld = vld_q;

    always_comb begin
        vld_nxt = vld_q;
        if (pop_ok) begin
            vld_nxt[rd_idx] = 1'b0;
        end
        if (push_ok) begin
            vld_nxt[wr_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            vld_q  <= '0;
        end else begin
            vld_q <= vld_nxt;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Payload storage needs no reset: slots are qualified by vld_q.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_idx] <= push_dat;
        end
    end

endmodule

// File: rtl/sreg_wb_arbiter.sv
// Writeback arbiter: merges ALU and LSU results onto the single register-file write port.
// Latency: ALU 1 cycle; LSU minimum 2 cycles (accept N, dequeue N+1, write port N+2).
// Backpressure: lsu_ready_o = !full (0 in reset); stall_o pulses after STARVE_LIMIT blocked cycles.
// Ports: clk, rst (async, active high), bus (slave modport: results, hazard query, write port, err).
module sreg_wb_arbiter
    import sreg_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_W,
    parameter int LSU_FIFO_DEPTH = 2,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic              clk,
    input  logic              rst,
    sreg_wb_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    wb_req_t                     fifo_head;
    wb_req_t [LSU_FIFO_DEPTH-1:0] fifo_entries;
    logic    [LSU_FIFO_DEPTH-1:0] fifo_vld;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        fifo_push;
    logic                        fifo_pop;
    wb_req_t                     lsu_req;

    logic                        alu_wr;
    logic                        lsu_ready;
    logic                        blocked;
    wb_src_e                     src;
    wb_req_t                     wb_nxt;

    logic [CNT_W-1:0]            starve_cnt;
    logic [CNT_W-1:0]            starve_inc;
    logic                        stall_q;
    logic                        err_q;
    logic                        wr_en_q;
    logic [REG_ADDR_W-1:0]       rd_addr_q;
    logic [DATA_WIDTH-1:0]       rd_data_q;
    logic                        pend1;
    logic                        pend2;

    assign alu_wr    = is_write(bus.alu_valid_i, bus.alu_rd_i);
    // Ready is held low during reset so nothing is accepted into a FIFO being cleared.
    assign lsu_ready = !fifo_full && !rst;
    // Loads to x0 are accepted (handshake completes) but never stored.
    assign fifo_push = bus.lsu_valid_i && lsu_ready && (bus.lsu_rd_i != '0);
    assign lsu_req   = '{rd: bus.lsu_rd_i, data: bus.lsu_data_i};
    assign blocked   = alu_wr && !fifo_empty;
    assign starve_inc = starve_cnt + CNT_W'(1);

    sreg_wb_fifo #(
        .DEPTH (LSU_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_dat  (lsu_req),
        .pop       (fifo_pop),
        .pop_dat   (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .entries   (fifo_entries),
        .entry_vld (fifo_vld)
    );

    // ALU has fixed priority; the FIFO head only drains in ALU-free cycles.
    always_comb begin
        src      = WB_NONE;
        fifo_pop = 1'b0;
        wb_nxt   = '0;
        if (alu_wr) begin
            src    = WB_ALU;
            wb_nxt = '{rd: bus.alu_rd_i, data: bus.alu_data_i};
        end else if (!fifo_empty) begin
            src      = WB_LSU;
            fifo_pop = 1'b1;
            wb_nxt   = fifo_head;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
            stall_q    <= 1'b0;
            err_q      <= 1'b0;
            starve_cnt <= '0;
        end else begin
            wr_en_q <= (src != WB_NONE);
            if (src != WB_NONE) begin
                rd_addr_q <= wb_nxt.rd;
                rd_data_q <= wb_nxt.data;
            end
            // An ALU write during the stall cycle still wins but is a protocol violation.
            err_q <= err_q | (stall_q && alu_wr);
            if (blocked) begin
                if (starve_inc == CNT_W'(STARVE_LIMIT)) begin
                    stall_q    <= 1'b1;
                    starve_cnt <= '0;
                end else begin
                    stall_q    <= 1'b0;
                    starve_cnt <= starve_inc;
                end
            end else begin
                stall_q    <= 1'b0;
                starve_cnt <= '0;
            end
        end
    end

    // Pending = buffered in the FIFO or sitting in the write-port register.
    always_comb begin
        pend1 = 1'b0;
        pend2 = 1'b0;
        for (int i = 0; i < LSU_FIFO_DEPTH; i++) begin
            if (fifo_vld[i] && (fifo_entries[i].rd == bus.rs1_addr_i)) pend1 = 1'b1;
            if (fifo_vld[i] && (fifo_entries[i].rd == bus.rs2_addr_i)) pend2 = 1'b1;
        end
        if (wr_en_q && (rd_addr_q == bus.rs1_addr_i)) pend1 = 1'b1;
        if (wr_en_q && (rd_addr_q == bus.rs2_addr_i)) pend2 = 1'b1;
        if (bus.rs1_addr_i == '0) pend1 = 1'b0;
        if (bus.rs2_addr_i == '0) pend2 = 1'b0;
    end

    assign bus.lsu_ready_o    = lsu_ready;
    assign bus.stall_o        = stall_q;
    assign bus.err_o          = err_q;
    assign bus.reg_write_en_o = wr_en_q;
    assign bus.rd_addr_o      = rd_addr_q;
    assign bus.rd_data_o      = rd_data_q;
    assign bus.pend_rs1_o     = pend1;
    assign bus.pend_rs2_o     = pend2;

endmodule

// File: doc/sreg_wb_arbiter.md
Name: sreg_wb_arbiter

Overview:
Writeback stage that sits directly upstream of the scalar register file and drives its single write port (rd_addr, rd_data, reg_write_en).
- Merges two result sources:
  - ALU results: fixed latency, priority, no backpressure.
  - LSU load results: variable latency, valid/ready, buffered in a small FIFO.
- Reports pending writes to decode so that RAW hazards are visible before the register file is updated.
- Includes an anti-starvation mechanism for the load path.

Parameters:
- DATA_WIDTH, 32, result/register data width.
- LSU_FIFO_DEPTH, 2, number of load-result entries buffered (power of two, >=2).
- STARVE_LIMIT, 4, number of consecutive cycles an ALU write may block a non-empty FIFO before stall_o is raised.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- alu_valid_i  in  1  ALU result present this cycle.
- alu_rd_i  in  5  ALU destination register.
- alu_data_i  in  DATA_WIDTH  ALU result.
- lsu_valid_i  in  1  load result offered.
- lsu_ready_o  out  1  FIFO can accept a load result.
- lsu_rd_i  in  5  load destination register.
- lsu_data_i  in  DATA_WIDTH  load data.
- stall_o  out  1  request to upstream: no ALU result next cycle.
- rs1_addr_i  in  5  decode source register 1 query.
- rs2_addr_i  in  5  decode source register 2 query.
- pend_rs1_o  out  1  write to rs1 still in flight.
- pend_rs2_o  out  1  write to rs2 still in flight.
- rd_addr_o  out  5  register file write address.
- rd_data_o  out  DATA_WIDTH  register file write data.
- reg_write_en_o  out  1  register file write enable.
- err_o  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst=1, asynchronous):
  - rd_addr_o, rd_data_o, reg_write_en_o, stall_o and err_o are 0.
  - FIFO is empty and the starvation counter is 0.
  - lsu_ready_o is 0 while rst=1 and becomes 1 in the first cycle after release.
  - Reset mid-operation discards all buffered writes.
- Output register: rd_addr_o, rd_data_o and reg_write_en_o are registered. The register file commits them at the following edge.
- A request counts as a write only if its valid is 1 and its rd is not 0. A write to x0 is dropped.
- ALU path:
  - A write presented in cycle N appears on the outputs in cycle N+1 (latency 1).
  - The ALU always wins arbitration.
- LSU path:
  - lsu_ready_o = !fifo_full. No same-cycle pass-through when the FIFO is full.
  - Accept when lsu_valid_i && lsu_ready_o.
  - An accepted load with rd=0 is discarded and not enqueued.
  - Minimum latency: accept in cycle N, dequeue in N+1, output in N+2.
- Arbitration each cycle:
  - If an ALU write is present, it is registered.
  - Otherwise, if the FIFO is non-empty, the head is dequeued and registered.
  - Otherwise reg_write_en_o is 0 next cycle.
- Simultaneous enqueue and dequeue in the same cycle are allowed when the FIFO is not full. Occupancy is unchanged.
- Starvation:
  - The counter increments in each cycle where an ALU write blocks a non-empty FIFO. It clears in any other cycle.
  - When the counter reaches STARVE_LIMIT, stall_o is registered high for exactly 1 cycle and the counter clears.
  - Upstream must not present an ALU write in the stall_o cycle. The FIFO head drains in that cycle.
  - If an ALU write arrives anyway, the ALU still wins and err_o sets. err_o clears only on reset.
- Pending query (combinational):
  - pend_rsX_o = 1 when rsX is not 0 and rsX matches the rd of any valid FIFO entry, or matches rd_addr_o while reg_write_en_o=1.
  - x0 is never pending.
- WAW ordering between ALU and LSU to the same rd is enforced upstream using pend_*. The arbiter does not reorder or detect it.
- FIFO pointers wrap modulo LSU_FIFO_DEPTH. A full/empty distinction uses an extra pointer bit.

Decomposition:
- Shared package sreg_pkg:
  - REG_ADDR_W = 5.
  - typedef wb_req_t {logic [4:0] rd; logic [DATA_WIDTH-1:0] data;}.
  - typedef wb_src_e {WB_NONE, WB_ALU, WB_LSU}.
- One sub-module: sreg_wb_fifo.
  - Synchronous FIFO of wb_req_t with push/pop/full/empty.
  - Exposes all entries plus per-entry valid bits for the pending comparison.

Test Plan:
1. ALU write rd=5, data=0xDEADBEEF in cycle 3 -> reg_write_en_o=1, rd_addr_o=5, rd_data_o=0xDEADBEEF in cycle 4 only.
2. LSU rd=7, data=0x12345678 accepted in cycle 2, no ALU traffic -> output in cycle 4; pend_rs1_o=1 for rs1_addr_i=7 in cycles 3-4 and 0 in cycle 5.
3. ALU rd=1 and LSU rd=2 both in cycle 2 -> x1 written in cycle 3, x2 in cycle 4.
4. Three LSU loads back-to-back with ALU busy -> lsu_ready_o=0 after two accepts; the third is accepted only after the first dequeue; all three written in order.
5. ALU writes every cycle with FIFO holding one entry -> stall_o=1 in exactly one cycle after 4 blocked cycles; FIFO entry written in the next cycle; an ALU write presented during stall_o sets err_o=1.
6. ALU and LSU writes with rd=0 -> no reg_write_en_o pulse, nothing enqueued. Assert rst with FIFO full -> all outputs 0 immediately, lsu_ready_o=1 the cycle after release.
